// File: rtl/lse_mult_unit.sv
// Log-domain multiplier: adds two two's-complement log values, forcing
// NEG_INF (log 0) on a NEG_INF operand or on signed overflow. One
// registered stage; results and the overflow flag hold while idle.
module lse_mult_unit #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [1:0]       pe_mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             ovf_flag
);

  localparam logic [WIDTH-1:0] NEG_INF = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] result_d, result_q;
  logic             ovf_d, ovf_q;
  logic             valid_q;

  // Legacy SIMD modes are deprecated; every mode behaves as scalar.
  logic unused_pe_mode;
  assign unused_pe_mode = ^pe_mode;

  // Modular sum, signed-overflow detect and priority selection of the result.
  always_comb begin
    sum      = operand_a + operand_b;
    sum_ovf  = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
               (sum[WIDTH-1] != operand_a[WIDTH-1]);
    result_d = sum;
    ovf_d    = 1'b0;
    if ((operand_a == NEG_INF) || (operand_b == NEG_INF)) begin
      result_d = NEG_INF;
      ovf_d    = 1'b0;
    end else if (sum_ovf) begin
      result_d = NEG_INF;
      ovf_d    = 1'b1;
    end
  end

  // Output stage: valid follows in_valid; data and flag load only on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_lse_mult_unit.sv
module tb_lse_mult_unit;

  localparam logic [23:0] NINF = 24'h800000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] operand_a = '0;
  logic [23:0] operand_b = '0;
  logic [1:0]  pe_mode = 2'b00;
  logic        out_valid;
  logic [23:0] result;
  logic        ovf_flag;

  int checks = 0;
  int errors = 0;

  lse_mult_unit #(.WIDTH(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .pe_mode   (pe_mode),
    .out_valid (out_valid),
    .result    (result),
    .ovf_flag  (ovf_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [1:0]  mode;
    logic [23:0] exp_r;
    logic        exp_o;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: signed integer arithmetic with an explicit range test.
  function automatic void model(input logic [23:0] a, input logic [23:0] b,
                                output logic [23:0] r, output logic o);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sa + sb;
    if (a == NINF || b == NINF) begin
      r = NINF; o = 1'b0;
    end else if (s > 8388607 || s < -8388608) begin
      r = NINF; o = 1'b1;
    end else begin
      r = s[23:0]; o = 1'b0;
    end
  endfunction

  function automatic logic [23:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return NINF;
      1:       return 24'h7FFF00 | 24'($urandom_range(0, 255));
      2:       return 24'h800000 | 24'($urandom_range(1, 255));
      3:       return 24'($urandom_range(0, 3)) - 24'd1;
      default: return 24'($urandom());
    endcase
  endfunction

  task automatic add_vec(input logic [23:0] a, input logic [23:0] b, input logic [1:0] m,
                         input logic [23:0] r, input logic o);
    vec_t v;
    v.a = a; v.b = b; v.mode = m; v.exp_r = r; v.exp_o = o;
    vecs.push_back(v);
  endtask

  initial begin
    logic [23:0] held_r;
    logic        held_o;
    logic [23:0] mr;
    logic        mo;
    logic        v;

    add_vec(24'h100000, 24'h200000, 2'b00, 24'h300000, 1'b0);
    add_vec(24'h050000, 24'h030000, 2'b00, 24'h080000, 1'b0);
    add_vec(24'h000000, 24'h123456, 2'b00, 24'h123456, 1'b0);
    add_vec(24'h123456, 24'h000000, 2'b00, 24'h123456, 1'b0);
    add_vec(24'h800000, 24'h123456, 2'b00, 24'h800000, 1'b0);
    add_vec(24'h123456, 24'h800000, 2'b00, 24'h800000, 1'b0);
    add_vec(24'h800000, 24'h800000, 2'b00, 24'h800000, 1'b0);
    add_vec(24'hFFFFFF, 24'h000001, 2'b00, 24'h000000, 1'b0);
    add_vec(24'h7FFFFF, 24'h000001, 2'b00, 24'h800000, 1'b1);
    add_vec(24'h800001, 24'hFFFFFE, 2'b00, 24'h800000, 1'b1);
    add_vec(24'hC00000, 24'hC00000, 2'b00, 24'h800000, 1'b0);
    add_vec(24'h7FFFFE, 24'h000001, 2'b00, 24'h7FFFFF, 1'b0);
    add_vec(24'h100000, 24'h200000, 2'b01, 24'h300000, 1'b0);
    add_vec(24'h7FFFFF, 24'h000001, 2'b00, 24'h800000, 1'b1);
    add_vec(24'h100000, 24'h200000, 2'b10, 24'h300000, 1'b0);
    add_vec(24'h100000, 24'h200000, 2'b11, 24'h300000, 1'b0);

    // Reset values while held in reset.
    #12;
    chk("rst_result", result, 24'h000000);
    chk("rst_valid", {23'd0, out_valid}, 24'd0);
    chk("rst_ovf", {23'd0, ovf_flag}, 24'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid", {23'd0, out_valid}, 24'd0);

    // Table vectors back to back, one result per cycle.
    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      operand_a = vecs[i].a; operand_b = vecs[i].b; pe_mode = vecs[i].mode;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), {23'd0, out_valid}, 24'd1);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp_r);
      chk($sformatf("vec%0d_ovf", i), {23'd0, ovf_flag}, {23'd0, vecs[i].exp_o});
    end

    // Hold: operands change while in_valid is low; outputs keep last result.
    @(negedge clk);
    in_valid = 1'b0; operand_a = 24'h111111; operand_b = 24'h222222; pe_mode = 2'b00;
    repeat (2) begin
      @(posedge clk); #1;
      chk("hold_valid", {23'd0, out_valid}, 24'd0);
      chk("hold_result", result, 24'h300000);
      chk("hold_ovf", {23'd0, ovf_flag}, 24'd0);
    end

    // Overflow flag must also hold while idle.
    @(negedge clk);
    in_valid = 1'b1; operand_a = 24'h800001; operand_b = 24'hFFFFFE;
    @(negedge clk);
    in_valid = 1'b0; operand_a = 24'h000001; operand_b = 24'h000001;
    @(posedge clk); #1;
    chk("hold_ovf_set", {23'd0, ovf_flag}, 24'd1);
    chk("hold_ovf_result", result, NINF);

    // Asynchronous reset mid-stream clears outputs before the next edge.
    @(negedge clk);
    in_valid = 1'b1; operand_a = 24'h010000; operand_b = 24'h020000;
    @(posedge clk); #2;
    chk("pre_rst_result", result, 24'h030000);
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", result, 24'h000000);
    chk("async_rst_valid", {23'd0, out_valid}, 24'd0);
    chk("async_rst_ovf", {23'd0, ovf_flag}, 24'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {23'd0, out_valid}, 24'd0);
    @(negedge clk);
    in_valid = 1'b1; operand_a = 24'h000005; operand_b = 24'hFFFFFD;
    @(posedge clk); #1;
    chk("post_rst_first_valid", {23'd0, out_valid}, 24'd1);
    chk("post_rst_first_result", result, 24'h000002);

    // Randomized traffic against the reference model.
    held_r = 24'h000002;
    held_o = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      v = ($urandom_range(0, 3) != 0);
      in_valid = v;
      operand_a = rand_op();
      operand_b = rand_op();
      pe_mode = 2'($urandom_range(0, 3));
      model(operand_a, operand_b, mr, mo);
      if (v) begin
        held_r = mr;
        held_o = mo;
      end
      @(posedge clk); #1;
      chk("rand_valid", {23'd0, out_valid}, {23'd0, v});
      chk("rand_result", result, held_r);
      chk("rand_ovf", {23'd0, ovf_flag}, {23'd0, held_o});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
